// File: rtl/factorial_pkg.sv
// Purpose: types and sizing constants shared by the factorial engine and its BCD readout stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package factorial_pkg;

   localparam int FACT_DATA_W     = 16;
   localparam int FACT_BCD_DIGITS = 5;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } bcd_state_t;

endpackage

// File: rtl/bcd_add3.sv
// Purpose: double-dabble digit correction, returns d+3 when d>=5 else d.
// Latency: combinational.
// Backpressure: none.
// Ports: d_in - one BCD digit before the shift; d_out - corrected digit.
module bcd_add3 (
   input  logic [3:0] d_in,
   output logic [3:0] d_out
);

   always_comb begin
      d_out = d_in;
      if (d_in >= 4'd5) begin
         d_out = d_in + 4'd3;
      end
   end

endmodule

// File: rtl/factorial_bcd.sv
// Purpose: capture factorial results on the engine's done strobe and convert them to packed BCD.
// Latency: 17 cycles from the in_valid cycle to the bcd_valid cycle; one IDLE cycle between back-to-back conversions.
// Backpressure: none upstream; one pending slot absorbs a strobe during a conversion, further strobes are dropped and flag overflow.
// Ports:
//   clk, reset_n       - clock, asynchronous active-low reset
//   in_valid, in_data  - one-cycle result strobe and value from the engine
//   bcd_out, bcd_valid - packed BCD (digit 0 in [3:0]) and its one-cycle update pulse
//   ndigits            - significant digit count, 1 for zero
//   busy, overflow     - converting or pending slot full; sticky dropped-input flag
module factorial_bcd
   import factorial_pkg::*;
#(
   parameter int DATA_W = FACT_DATA_W,
   parameter int DIGITS = FACT_BCD_DIGITS
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   input  logic [DATA_W-1:0]     in_data,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  bcd_valid,
   output logic [2:0]            ndigits,
   output logic                  busy,
   output logic                  overflow
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   bcd_state_t             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [DATA_W-1:0]      bin_q, bin_d;
   logic [4*DIGITS-1:0]    bcd_q, bcd_d;
   logic                   pend_v_q, pend_v_d;
   logic [DATA_W-1:0]      pend_data_q, pend_data_d;
   logic [4*DIGITS-1:0]    bcd_out_q, bcd_out_d;
   logic [2:0]             ndigits_q, ndigits_d;
   logic                   bcd_valid_q, bcd_valid_d;
   logic                   busy_q, busy_d;
   logic                   overflow_q, overflow_d;

   logic [4*DIGITS-1:0]    bcd_adj;
   logic [4*DIGITS-1:0]    bcd_sh;
   logic [DATA_W-1:0]      bin_sh;

   // Highest nonzero digit index + 1; a value of zero still shows one digit.
   function automatic logic [2:0] count_digits(input logic [4*DIGITS-1:0] b);
      logic [2:0] n;
      n = 3'd1;
      for (int i = 0; i < DIGITS; i++) begin
         if (b[4*i +: 4] != 4'd0) begin
            n = 3'(i + 1);
         end
      end
      return n;
   endfunction

   // Digits are corrected independently; no carry crosses digits before the shift.
   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .d_in  (bcd_q[4*g +: 4]),
         .d_out (bcd_adj[4*g +: 4])
      );
   end

   always_comb begin
      {bcd_sh, bin_sh} = {bcd_adj, bin_q} << 1;
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bin_d       = bin_q;
      bcd_d       = bcd_q;
      pend_v_d    = pend_v_q;
      pend_data_d = pend_data_q;
      bcd_out_d   = bcd_out_q;
      ndigits_d   = ndigits_q;
      bcd_valid_d = 1'b0;
      overflow_d  = overflow_q;

      case (state_q)
         IDLE: begin
            if (pend_v_q) begin
               // Pending entry has priority; a same-cycle strobe refills the slot.
               bin_d    = pend_data_q;
               pend_v_d = in_valid;
               if (in_valid) begin
                  pend_data_d = in_data;
               end
               cnt_d   = '0;
               bcd_d   = '0;
               state_d = SHIFT;
            end else if (in_valid) begin
               bin_d   = in_data;
               cnt_d   = '0;
               bcd_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            bcd_d = bcd_sh;
            bin_d = bin_sh;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               bcd_out_d   = bcd_sh;
               ndigits_d   = count_digits(bcd_sh);
               bcd_valid_d = 1'b1;
               cnt_d       = '0;
               state_d     = IDLE;
            end
            // Strobes while converting (including the final edge) go to the slot;
            // a full slot keeps its value and the new input is lost.
            if (in_valid) begin
               if (!pend_v_q) begin
                  pend_v_d    = 1'b1;
                  pend_data_d = in_data;
               end else begin
                  overflow_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == SHIFT) | pend_v_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bin_q       <= '0;
         bcd_q       <= '0;
         pend_v_q    <= 1'b0;
         pend_data_q <= '0;
         bcd_out_q   <= '0;
         ndigits_q   <= 3'd1;
         bcd_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bin_q       <= bin_d;
         bcd_q       <= bcd_d;
         pend_v_q    <= pend_v_d;
         pend_data_q <= pend_data_d;
         bcd_out_q   <= bcd_out_d;
         ndigits_q   <= ndigits_d;
         bcd_valid_q <= bcd_valid_d;
         busy_q      <= busy_d;
         overflow_q  <= overflow_d;
      end
   end

   assign bcd_out   = bcd_out_q;
   assign bcd_valid = bcd_valid_q;
   assign ndigits   = ndigits_q;
   assign busy      = busy_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_factorial_bcd.sv
// Purpose: self-checking bench for factorial_bcd against a transaction-level timing/decimal model.
// Latency: n/a.
// Backpressure: n/a.
module tb_factorial_bcd;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_data = '0;
   logic [19:0] bcd_out;
   logic        bcd_valid;
   logic [2:0]  ndigits;
   logic        busy;
   logic        overflow;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   factorial_bcd dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .bcd_out   (bcd_out),
      .bcd_valid (bcd_valid),
      .ndigits   (ndigits),
      .busy      (busy),
      .overflow  (overflow)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Decimal reference: plain division by ten.
   function automatic logic [19:0] to_bcd(input int v);
      logic [19:0] r;
      r = '0;
      for (int i = 0; i < 5; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic int ref_ndigits(input int v);
      int n;
      int t;
      n = 1;
      t = v / 10;
      while (t > 0) begin
         n++;
         t = t / 10;
      end
      return n;
   endfunction

   // Transaction model: a conversion started at edge E completes at edge E+16;
   // one waiting slot, later arrivals are lost; idle picks the slot first.
   int  cyc = 0;
   bit  m_active;
   int  m_end;
   int  m_val;
   int  m_pend[$];
   bit  m_ovf;
   bit  m_vld_exp;
   int  m_last;

   always @(posedge clk) begin
      cyc++;
      m_vld_exp = 1'b0;
      if (!reset_n) begin
         m_active = 1'b0;
         m_pend.delete();
         m_ovf    = 1'b0;
         m_last   = 0;
      end else if (m_active) begin
         if (in_valid) begin
            if (m_pend.size() == 0) m_pend.push_back(int'(in_data));
            else m_ovf = 1'b1;
         end
         if (cyc == m_end) begin
            m_active  = 1'b0;
            m_vld_exp = 1'b1;
            m_last    = m_val;
         end
      end else begin
         if (m_pend.size() != 0) begin
            m_val    = m_pend.pop_front();
            m_active = 1'b1;
            m_end    = cyc + 16;
            if (in_valid) m_pend.push_back(int'(in_data));
         end else if (in_valid) begin
            m_val    = int'(in_data);
            m_active = 1'b1;
            m_end    = cyc + 16;
         end
      end
   end

   bit chk_en = 1'b0;
   int vld_cyc[$];

   always @(negedge clk) begin
      if (chk_en && reset_n) begin
         if (bcd_valid) vld_cyc.push_back(cyc);
         check("bcd_valid", 32'(bcd_valid), 32'(m_vld_exp));
         check("bcd_out", 32'(bcd_out), 32'(to_bcd(m_last)));
         check("ndigits", 32'(ndigits), 32'(ref_ndigits(m_last)));
         check("busy", 32'(busy), 32'(m_active || (m_pend.size() != 0)));
         check("overflow", 32'(overflow), 32'(m_ovf));
      end
   end

   // All stimulus helpers are called at a negedge.
   task automatic goto_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic drive(input logic [15:0] v);
      in_valid = 1'b1;
      in_data  = v;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 16'($urandom);
   endtask

   task automatic do_reset();
      #2 reset_n = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      #2 reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " bcd_out"}, 32'(bcd_out), 32'h0);
      check({tag, " bcd_valid"}, 32'(bcd_valid), 32'h0);
      check({tag, " ndigits"}, 32'(ndigits), 32'h1);
      check({tag, " busy"}, 32'(busy), 32'h0);
      check({tag, " overflow"}, 32'(overflow), 32'h0);
   endtask

   initial begin
      int s;
      int v;
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b1;
      @(negedge clk);
      check_reset_values("reset");
      chk_en = 1'b1;

      // 5! : latency from strobe cycle to valid cycle.
      vld_cyc.delete();
      s = cyc;
      drive(16'd120);
      goto_cyc(s + 30);
      check("t1 pulses", 32'(vld_cyc.size()), 32'd1);
      if (vld_cyc.size() >= 1) check("t1 latency", 32'(vld_cyc[0] - s), 32'd17);

      // Extremes.
      drive(16'd0);
      goto_cyc(cyc + 20);
      drive(16'd65535);
      goto_cyc(cyc + 20);

      // Second strobe 3 cycles later goes to the slot.
      vld_cyc.delete();
      s = cyc;
      drive(16'd40320);
      goto_cyc(s + 3);
      drive(16'd35200);
      goto_cyc(s + 45);
      check("t3 pulses", 32'(vld_cyc.size()), 32'd2);
      if (vld_cyc.size() >= 2) check("t3 spacing", 32'(vld_cyc[1] - vld_cyc[0]), 32'd17);
      check("t3 overflow", 32'(overflow), 32'h0);

      // Three strobes in one conversion: third is dropped.
      vld_cyc.delete();
      s = cyc;
      drive(16'd720);
      goto_cyc(s + 2);
      drive(16'd5040);
      goto_cyc(s + 4);
      drive(16'd24);
      goto_cyc(s + 60);
      check("t4 pulses", 32'(vld_cyc.size()), 32'd2);
      check("t4 overflow", 32'(overflow), 32'h1);

      // Reset mid-conversion.
      vld_cyc.delete();
      s = cyc;
      drive(16'd5040);
      goto_cyc(s + 8);
      do_reset();
      check_reset_values("t5 abort");
      goto_cyc(cyc + 20);
      check("t5 no pulse", 32'(vld_cyc.size()), 32'd0);
      drive(16'd6);
      goto_cyc(cyc + 20);

      // Strobe on the final SHIFT cycle.
      vld_cyc.delete();
      s = cyc;
      drive(16'd24);
      goto_cyc(s + 16);
      drive(16'd120);
      goto_cyc(s + 45);
      check("t6 pulses", 32'(vld_cyc.size()), 32'd2);
      if (vld_cyc.size() >= 2) check("t6 spacing", 32'(vld_cyc[1] - vld_cyc[0]), 32'd17);

      // Random traffic with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 399) == 0) begin
            do_reset();
         end else begin
            in_valid = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 3))
               0: v = 0;
               1: v = 65535;
               2: v = $urandom_range(0, 99);
               default: v = $urandom_range(0, 65535);
            endcase
            in_data = 16'(v);
            @(negedge clk);
         end
      end
      in_valid = 1'b0;
      goto_cyc(cyc + 40);
      chk_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/factorial_bcd.md
# factorial_bcd

Downstream stage of the factorial engine. It captures each finished 16-bit factorial result on the engine's one-cycle `done` pulse and converts it to packed BCD with a sequential shift-add-3 (double-dabble) datapath. It presents five decimal digits plus a significant-digit count to the display/readout logic. A one-entry holding register absorbs a result that arrives while a conversion is in flight.

## Interface
- `DATA_W`, 16: binary input width; one shift per bit.
- `DIGITS`, 5: BCD digit count; must satisfy 10^DIGITS > 2^DATA_W - 1.
- `clk`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `in_valid`  in  1: one-cycle strobe, driven by the factorial engine's `done`.
- `in_data`  in  DATA_W: result to convert, driven by the factorial engine's `fdata_out`; sampled only when `in_valid`=1.
- `bcd_out`  out  4*DIGITS: packed BCD, digit 0 in [3:0]; held until the next completion.
- `bcd_valid`  out  1: one-cycle pulse when `bcd_out` updates.
- `ndigits`  out  3: significant digits in `bcd_out` (1..DIGITS); 1 for a value of 0.
- `busy`  out  1: high while converting or while the pending slot is full.
- `overflow`  out  1: sticky; set when an input is dropped; cleared only by reset.

## Operation
- States: IDLE, SHIFT.
- IDLE:
  - If `pend_v`=1: load `pend_data` into the shift register and clear `pend_v`. If `in_valid`=1 in the same cycle, that input goes into pending.
  - Else if `in_valid`=1: load `in_data`.
  - Any load sets `cnt`=0, clears the BCD accumulator, and moves to SHIFT.
- SHIFT, on each edge:
  - Every BCD digit ≥5 gets +3.
  - Then shift {bcd, bin} left by 1 and increment `cnt`.
  - On the edge with `cnt`=DATA_W-1: write the final BCD into `bcd_out`, write `ndigits`, pulse `bcd_valid`, and return to IDLE.
- `in_valid` during SHIFT:
  - If `pend_v`=0: store into pending and set `pend_v`=1.
  - If `pend_v`=1: drop the input and set `overflow`=1. The stored pending value is kept, not overwritten.
- `busy` = (state==SHIFT) | `pend_v`.
- `ndigits` = index of the highest nonzero digit + 1, minimum 1. It is computed from the final BCD value.
- Arithmetic: no truncation is possible for DATA_W=16 and DIGITS=5 (max 65535). The add-3 logic operates on 4-bit digits only; there is no carry between digits before the shift.

## Timing
- Reset values: `bcd_out`=0, `bcd_valid`=0, `ndigits`=1, `busy`=0, `overflow`=0. Internally: state=IDLE, `pend_v`=0, `cnt`=0.
- Reset mid-conversion aborts immediately. The pending entry is discarded and no `bcd_valid` is issued.
- Capture edge E (`in_valid` sampled in IDLE) → `bcd_valid` is high in the cycle after edge E+DATA_W (16). Latency is 17 cycles from the strobe cycle to the valid cycle.
- Throughput with a pending entry: IDLE lasts one cycle between conversions, so the next `bcd_valid` follows 17 cycles after the previous one.
- `in_valid` in the same cycle as the final SHIFT edge counts as "during SHIFT" and goes to pending (or is dropped if pending is full).
- `bcd_out` and `ndigits` change only on a completion edge.
- All outputs are registered.

## Structure
- `factorial_pkg` (shared with the factorial engine):
  - `bcd_state_t` {IDLE, SHIFT}.
  - Constants `FACT_DATA_W`=16 and `FACT_BCD_DIGITS`=5, used as parameter defaults.
- Sub-module `bcd_add3`: combinational, 4-bit in/out, returns d+3 when d≥5, else d. Instantiated once per digit with a generate loop.
- The top-level module holds the FSM, the counter, the shift register, the pending slot and the output registers.

## Test plan
1. Reset, then `in_valid` with 120 (5!) → `bcd_valid` 17 cycles later; `bcd_out`=20'h00120, `ndigits`=3, `busy` low afterwards.
2. Inputs 0 and 65535 on separate conversions → 20'h00000 with `ndigits`=1; then 20'h65535 with `ndigits`=5.
3. 40320 (8!), then 35200 (9! truncated) strobed 3 cycles later → two pulses 17 cycles apart: 20'h40320 with `ndigits`=5, then 20'h35200; `overflow`=0.
4. Three strobes (720, 5040, 24) within one conversion → outputs 20'h00720 and 20'h05040 only; 24 is dropped; `overflow`=1 and stays high until reset.
5. Strobe 5040, then assert `reset_n` low at cycle 8 and release → no `bcd_valid`; all outputs at reset values. A following strobe of 6 yields 20'h00006, `ndigits`=1.
6. Strobe arriving on the final SHIFT cycle → held in pending. It is converted after one IDLE cycle, with `bcd_valid` exactly 17 cycles after the first.
